// File: rtl/icache_pkg.sv
// Package for the instruction cache.
// Holds the refill FSM state type, the line geometry (16-byte blocks of
// four 32-bit words) and the word-select width. Imported by every
// instruction cache source file.
package icache_pkg;

  // Refill controller states; exposed on the top level as a debug output.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_READ = 2'd1,
    UPDATE   = 2'd2
  } icache_state_t;

  localparam int BLOCK_BYTES   = 16;  // bytes per cache line
  localparam int OFFSET_BITS   = 4;   // log2(BLOCK_BYTES)
  localparam int WORD_SEL_BITS = 2;   // selects one of four 32-bit words
  localparam int BLOCK_BITS    = BLOCK_BYTES * 8;

endpackage

// File: rtl/icache_data_array.sv
// Line storage for the direct-mapped instruction cache.
// One entry per set: 128-bit data block, tag and valid bit.
// Writes are synchronous, reads are combinational.
// Only the valid bits are cleared by reset; data and tags are left as-is
// because an invalid line is never reported as a hit.
//
// Ports:
//   clock, reset    : clock and synchronous active-low reset
//   write_en        : write the line at write_index on the rising edge
//   write_index     : set being refilled
//   write_tag       : tag stored with the refilled line
//   write_data      : refilled 128-bit block
//   read_index      : set looked up this cycle
//   read_valid      : valid bit of the looked-up set
//   read_tag        : stored tag of the looked-up set
//   read_data       : stored block of the looked-up set
module icache_data_array
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = 3,
  parameter int TAG_BITS   = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  write_en,
  input  logic [INDEX_BITS-1:0] write_index,
  input  logic [TAG_BITS-1:0]   write_tag,
  input  logic [BLOCK_BITS-1:0] write_data,
  input  logic [INDEX_BITS-1:0] read_index,
  output logic                  read_valid,
  output logic [TAG_BITS-1:0]   read_tag,
  output logic [BLOCK_BITS-1:0] read_data
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [BLOCK_BITS-1:0] data_mem [LINES];
  logic [TAG_BITS-1:0]   tag_mem  [LINES];
  logic [LINES-1:0]      valid_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      valid_q <= '0;
    end else if (write_en) begin
      valid_q[write_index] <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (write_en) begin
      data_mem[write_index] <= write_data;
      tag_mem[write_index]  <= write_tag;
    end
  end

  assign read_valid = valid_q[read_index];
  assign read_tag   = tag_mem[read_index];
  assign read_data  = data_mem[read_index];

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped, read-only instruction cache with 16-byte lines.
// Hits return the instruction word in the same cycle; a miss stalls the
// CPU while a whole block is fetched from instruction memory.
//
// Handshake: the CPU holds read=1 and a stable address until it samples
// busywait=0 at a rising edge; that edge accepts readinst. Toward memory,
// mem_read=1 with mem_address is held until mem_busywait is seen low at a
// rising edge, at which point mem_readinst must carry the block and stay
// stable for one more cycle (the UPDATE cycle writes it into the line).
//
// Optional feature: define ICACHE_STATS_EN to add saturating hit/miss
// counters (hit_count, miss_count).
//
// Ports:
//   clock, reset   : clock and synchronous active-low reset
//   read, address  : CPU fetch request and byte address
//   readinst       : fetched instruction word (combinational)
//   busywait       : CPU stall
//   mem_read       : block fetch request to instruction memory
//   mem_address    : block address {tag,index}
//   mem_readinst   : returned block, byte k at bits [8k+7:8k]
//   mem_busywait   : memory busy
//   fsm_state      : current refill controller state (debug)
//   hit_count      : accepted hits (ICACHE_STATS_EN only)
//   miss_count     : refills started (ICACHE_STATS_EN only)
module instruction_cache
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = 3,
  parameter int ADDR_BITS  = 10
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           read,
  input  logic [ADDR_BITS-1:0]           address,
  output logic [31:0]                    readinst,
  output logic                           busywait,
  output logic                           mem_read,
  output logic [ADDR_BITS-OFFSET_BITS-1:0] mem_address,
  input  logic [BLOCK_BITS-1:0]          mem_readinst,
  input  logic                           mem_busywait,
`ifdef ICACHE_STATS_EN
  output logic [15:0]                    hit_count,
  output logic [15:0]                    miss_count,
`endif
  output icache_state_t                  fsm_state
);

  localparam int TAG_BITS  = ADDR_BITS - OFFSET_BITS - INDEX_BITS;
  localparam int BLK_BITS  = ADDR_BITS - OFFSET_BITS;

  // Address decode; the byte-within-word bits are deliberately ignored.
  logic [TAG_BITS-1:0]      tag;
  logic [INDEX_BITS-1:0]    index;
  logic [WORD_SEL_BITS-1:0] word;
  logic                     unused_byte_bits;

  assign tag              = address[ADDR_BITS-1 -: TAG_BITS];
  assign index            = address[OFFSET_BITS +: INDEX_BITS];
  assign word             = address[OFFSET_BITS-1 -: WORD_SEL_BITS];
  assign unused_byte_bits = ^address[OFFSET_BITS-WORD_SEL_BITS-1:0];

  icache_state_t            state;
  logic [BLK_BITS-1:0]      miss_addr;
  logic                     refill_done;  // first IDLE cycle after UPDATE

  logic                     line_valid;
  logic [TAG_BITS-1:0]      line_tag;
  logic [BLOCK_BITS-1:0]    line_data;
  logic                     hit;
  logic                     write_en;

  // A refill in progress is dropped by reset: the line must stay untouched.
  assign write_en = (state == UPDATE) && reset;

  icache_data_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_data_array (
    .clock       (clock),
    .reset       (reset),
    .write_en    (write_en),
    .write_index (miss_addr[INDEX_BITS-1:0]),
    .write_tag   (miss_addr[BLK_BITS-1 -: TAG_BITS]),
    .write_data  (mem_readinst),
    .read_index  (index),
    .read_valid  (line_valid),
    .read_tag    (line_tag),
    .read_data   (line_data)
  );

  assign hit      = read && line_valid && (line_tag == tag);
  assign readinst = line_data[word*32 +: 32];

  // Stall only on a miss while idle; the refill states always stall.
  assign busywait = (state == IDLE) ? (read && !hit) : 1'b1;

  assign fsm_state = state;

  // Refill controller. mem_read/mem_address are registered alongside the
  // state so they are high exactly while in MEM_READ and zero otherwise.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= IDLE;
      miss_addr   <= '0;
      mem_read    <= 1'b0;
      mem_address <= '0;
      refill_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          refill_done <= 1'b0;
          if (read && !hit) begin
            miss_addr   <= {tag, index};
            mem_address <= {tag, index};
            mem_read    <= 1'b1;
            state       <= MEM_READ;
          end
        end
        MEM_READ: begin
          // The first edge here already follows one full cycle in
          // MEM_READ, so only mem_busywait gates the exit.
          if (!mem_busywait) begin
            mem_read    <= 1'b0;
            mem_address <= '0;
            state       <= UPDATE;
          end
        end
        UPDATE: begin
          refill_done <= 1'b1;
          state       <= IDLE;
        end
        default: begin
          mem_read    <= 1'b0;
          mem_address <= '0;
          state       <= IDLE;
        end
      endcase
    end
  end

`ifdef ICACHE_STATS_EN
  // The hit that completes a refill belongs to the miss already counted,
  // so it is excluded from hit_count.
  always_ff @(posedge clock) begin
    if (!reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state == IDLE) begin
      if (hit && !refill_done && (hit_count != 16'hFFFF)) begin
        hit_count <= hit_count + 16'd1;
      end
      if (read && !hit && (miss_count != 16'hFFFF)) begin
        miss_count <= miss_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_instruction_cache.sv
// Testbench for instruction_cache: directed fetches with hand-computed
// instruction words, a behavioural instruction memory, and a scoreboard
// monitor that checks readinst whenever a fetch is accepted.
module tb_instruction_cache;
  import icache_pkg::*;

  localparam int INDEX_BITS = 3;
  localparam int ADDR_BITS  = 10;
  localparam int BLK_BITS   = ADDR_BITS - 4;
  localparam int MEM_LAT    = 3;
  localparam int WAIT_MAX   = 50;

  // ---------------- clock / reset / DUT ----------------
  logic                  clock = 1'b0;
  logic                  reset = 1'b0;
  logic                  read = 1'b0;
  logic [ADDR_BITS-1:0]  address = '0;
  logic [31:0]           readinst;
  logic                  busywait;
  logic                  mem_read;
  logic [BLK_BITS-1:0]   mem_address;
  logic [127:0]          mem_readinst = '0;
  logic                  mem_busywait = 1'b0;
  icache_state_t         fsm_state;
`ifdef ICACHE_STATS_EN
  logic [15:0]           hit_count;
  logic [15:0]           miss_count;
`endif

  always #5 clock = ~clock;

  instruction_cache #(
    .INDEX_BITS (INDEX_BITS),
    .ADDR_BITS  (ADDR_BITS)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .read         (read),
    .address      (address),
    .readinst     (readinst),
    .busywait     (busywait),
    .mem_read     (mem_read),
    .mem_address  (mem_address),
    .mem_readinst (mem_readinst),
    .mem_busywait (mem_busywait),
`ifdef ICACHE_STATS_EN
    .hit_count    (hit_count),
    .miss_count   (miss_count),
`endif
    .fsm_state    (fsm_state)
  );

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- instruction memory model ----------------
  // Block b holds words 0xC0DE_0000 | b<<4 | w, except block 0 which holds
  // the program words used by the directed checks.
  logic [127:0]        blocks [64];
  int                  mem_cnt = 0;
  logic [BLK_BITS-1:0] mem_blk = '0;

  initial begin
    for (int b = 0; b < 64; b++) begin
      for (int w = 0; w < 4; w++) begin
        blocks[b][w*32 +: 32] = 32'hC0DE_0000 | (b << 4) | w;
      end
    end
    blocks[0] = {32'h0703000B, 32'h0702000A, 32'h07010001, 32'h07000009};
  end

  // Raises busywait on seeing a request, drops it with the block after
  // MEM_LAT cycles and then holds the block stable.
  always @(negedge clock) begin
    if (mem_cnt > 0) begin
      mem_cnt = mem_cnt - 1;
      if (mem_cnt == 0) begin
        mem_busywait = 1'b0;
        mem_readinst = blocks[mem_blk];
      end
    end else if (mem_read) begin
      mem_busywait = 1'b1;
      mem_blk      = mem_address;
      mem_cnt      = MEM_LAT;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    if (reset && read && !busywait) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL readinst_unexpected: got %h expected no fetch at %0t", readinst, $time);
      end else begin
        check("readinst", readinst, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;
    read  = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    @(negedge clock);
    check("rst_busywait", 32'(busywait), 32'd0);
    check("rst_mem_read", 32'(mem_read), 32'd0);
    check("rst_mem_address", 32'(mem_address), 32'd0);
    check("rst_state", 32'(fsm_state), 32'(IDLE));
`ifdef ICACHE_STATS_EN
    check("rst_hit_count", 32'(hit_count), 32'd0);
    check("rst_miss_count", 32'(miss_count), 32'd0);
`endif
  endtask

  // Issue one fetch and hold it until accepted. For a miss, also check the
  // memory request and its block address.
  task automatic do_read(input logic [ADDR_BITS-1:0] a, input logic [31:0] exp_word,
                         input logic exp_miss, input logic [BLK_BITS-1:0] exp_blk);
    int  cyc;
    bit  seen;
    @(posedge clock);
    #1;
    read    = 1'b1;
    address = a;
    exp_q.push_back(exp_word);
    @(negedge clock);
    check("busywait_first", 32'(busywait), 32'(exp_miss));
    check("mem_read_first", 32'(mem_read), 32'd0);
    if (exp_miss) begin
      seen = 1'b0;
      cyc  = 0;
      while (busywait && cyc < WAIT_MAX) begin
        if (mem_read && !seen) begin
          seen = 1'b1;
          check("mem_address", 32'(mem_address), 32'(exp_blk));
        end
        @(negedge clock);
        cyc++;
      end
      check("mem_read_seen", 32'(seen), 32'd1);
      check("refill_in_time", 32'(cyc < WAIT_MAX), 32'd1);
    end
    @(posedge clock);
    #1;
    read = 1'b0;
  endtask

  // Reset pulsed for one edge while a refill is outstanding.
  task automatic abort_refill(input logic [ADDR_BITS-1:0] a);
    int cyc = 0;
    @(posedge clock);
    #1;
    read    = 1'b1;
    address = a;
    @(negedge clock);
    while (!mem_read && cyc < WAIT_MAX) begin
      @(negedge clock);
      cyc++;
    end
    check("abort_mem_read_seen", 32'(mem_read), 32'd1);
    @(posedge clock);
    #1;
    reset = 1'b0;
    read  = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(negedge clock);
    check("abort_state", 32'(fsm_state), 32'(IDLE));
    check("abort_mem_read", 32'(mem_read), 32'd0);
    check("abort_busywait", 32'(busywait), 32'd0);
    // Let the late memory response arrive while the cache is idle.
    repeat (MEM_LAT + 3) @(negedge clock);
    check("abort_late_resp_state", 32'(fsm_state), 32'(IDLE));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    do_reset();
    do_read(10'h000, 32'h07000009, 1'b1, 6'h00);  // cold miss, word 0
    do_read(10'h004, 32'h07010001, 1'b0, 6'h00);  // same-cycle hit, word 1
    do_read(10'h00C, 32'h0703000B, 1'b0, 6'h00);  // word 3 = bits [127:96]
    do_read(10'h00D, 32'h0703000B, 1'b0, 6'h00);  // byte bits ignored
    do_read(10'h008, 32'h0702000A, 1'b0, 6'h00);  // word 2
    do_read(10'h080, 32'hC0DE0080, 1'b1, 6'h08);  // index 0, tag 1: conflict
    do_read(10'h084, 32'hC0DE0081, 1'b0, 6'h08);  // new line now resident
    do_read(10'h000, 32'h07000009, 1'b1, 6'h00);  // old line was overwritten
    abort_refill(10'h040);
    do_read(10'h040, 32'hC0DE0040, 1'b1, 6'h04);  // aborted line still invalid
    do_read(10'h044, 32'hC0DE0041, 1'b0, 6'h04);
    do_read(10'h3F8, 32'hC0DE03F2, 1'b1, 6'h3F);  // highest block, index 7
`ifdef ICACHE_STATS_EN
    do_reset();
    do_read(10'h000, 32'h07000009, 1'b1, 6'h00);
    do_read(10'h004, 32'h07010001, 1'b0, 6'h00);
    do_read(10'h080, 32'hC0DE0080, 1'b1, 6'h08);
    @(negedge clock);
    check("hit_count", 32'(hit_count), 32'd1);
    check("miss_count", 32'(miss_count), 32'd2);
`endif
    repeat (2) @(negedge clock);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/instruction_cache.md
INSTRUCTION_CACHE -- requirements
Module: instruction_cache

Interface
REQ-001 SHALL have parameter INDEX_BITS, default 3: set-index width, giving 2^INDEX_BITS direct-mapped 16-byte lines.
REQ-002 SHALL have parameter ADDR_BITS, default 10: CPU byte-address width; tag width = ADDR_BITS-4-INDEX_BITS.
REQ-003 SHALL have port clock, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-low reset.
REQ-005 SHALL have port read, input, 1: CPU fetch request.
REQ-006 SHALL have port address, input, ADDR_BITS: CPU byte address (PC).
REQ-007 SHALL have port readinst, output, 32: fetched instruction word.
REQ-008 SHALL have port busywait, output, 1: CPU stall.
REQ-009 SHALL have port mem_read, output, 1: block-fetch request to instruction memory.
REQ-010 SHALL have port mem_address, output, ADDR_BITS-4: block address {tag,index}.
REQ-011 SHALL have port mem_readinst, input, 128: returned block; byte k at bits [8k+7:8k].
REQ-012 SHALL have port mem_busywait, input, 1: memory busy.

Function
REQ-013 SHALL decode the address as offset=[3:0], word=[3:2], index=[INDEX_BITS+3:4], tag=upper bits; address[1:0] ignored.
REQ-014 SHALL use hit = read && valid[index] && (tag_array[index]==tag), evaluated combinationally.
REQ-015 SHALL drive readinst combinationally as word [word] of data_array[index], bits [32w+31:32w].
REQ-016 SHALL drive busywait=0 when read=0 or on a hit in IDLE: zero-latency hit, same cycle.
REQ-017 SHALL use FSM states IDLE, MEM_READ, UPDATE.
REQ-018 SHALL, in IDLE with read && !hit: assert busywait combinationally, latch {tag,index} into miss_addr, and go to MEM_READ on the next edge.
REQ-019 SHALL, in MEM_READ: hold mem_read=1, mem_address=miss_addr, busywait=1.
REQ-020 SHALL leave MEM_READ for UPDATE only on an edge where mem_busywait=0 after at least one full cycle in MEM_READ; mem_busywait high at entry is tolerated.
REQ-021 SHALL, in UPDATE: mem_read=0, busywait=1; write mem_readinst, tag and valid=1 to line miss_addr index on the edge; then go to IDLE.
REQ-022 SHALL re-evaluate hit in IDLE after refill, so the refilled address hits with busywait=0 the cycle after UPDATE.
REQ-023 SHALL require the CPU to hold address stable while busywait=1; the refill uses miss_addr regardless.
REQ-024 SHALL refill a conflicting line by overwriting it (no victim handling; instructions are read-only).
REQ-025 SHALL drive mem_read=0 and mem_address=0 in IDLE and UPDATE.

Reset
REQ-026 SHALL, when reset=0 at an edge: state=IDLE, all valid bits=0, miss_addr=0.
REQ-027 SHALL, after reset, have outputs mem_read=0, mem_address=0, and busywait=0 until a read arrives.
REQ-028 SHALL abort any refill on reset in MEM_READ or UPDATE: no line written, mem_read dropped next cycle, the late memory response ignored.
REQ-029 SHALL NOT reset data_array or tag_array.

Configuration
REQ-030 SHALL, with ICACHE_STATS_EN defined, add outputs hit_count[15:0] and miss_count[15:0], both saturating at 0xFFFF and cleared by reset.
REQ-031 SHALL increment hit_count once per accepted hit and miss_count once per IDLE->MEM_READ transition.
REQ-032 SHALL, without ICACHE_STATS_EN, have no counter ports or logic.

Structure
REQ-033 SHALL place the state typedef (IDLE/MEM_READ/UPDATE), the block-size constant (16 bytes) and the word-select width in package icache_pkg.
REQ-034 SHALL implement the line storage (data, tag, valid; synchronous write, combinational read) as sub-module icache_data_array.

Verification
REQ-035 SHALL cover: reset, then read address 0x000 -> miss, mem_read=1, mem_address=0x00; memory returns a block with word0=0x07000009 -> UPDATE, then readinst=0x07000009 and busywait=0.
REQ-036 SHALL cover: then address 0x004 -> same-cycle hit, readinst=0x07010001, busywait=0, mem_read stays 0.
REQ-037 SHALL cover: address 0x00C -> hit returning bits [127:96] of line 0; address 0x00D returns the same word.
REQ-038 SHALL cover: address 0x080 (index 0, tag 1) -> miss with mem_address=0x08, line 0 overwritten; a following read of 0x000 misses again.
REQ-039 SHALL cover: reset=0 for one edge during MEM_READ -> state IDLE, mem_read=0 next cycle, line still invalid, and a re-read of the same address misses.
REQ-040 SHALL cover, with ICACHE_STATS_EN: the sequence 0x000, 0x004, 0x080 -> hit_count=1, miss_count=2.
